// File: rtl/seg_add_scan_if.sv
// Handshake and datapath bundle between the add/scan sequencer and its surroundings:
// operand handshake, shared adder hookup, and the multiplexed display outputs.
interface seg_add_scan_if;
    logic [3:0] x;
    logic [3:0] y;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [3:0] seg_in;
    logic [3:0] digit_en;
    logic       res_valid;

    // Environment side: supplies operands and the adder result, observes the display.
    modport master (
        output x, y, in_valid, add_sum, add_cout,
        input  in_ready, add_a, add_b, seg_in, digit_en, res_valid
    );

    // Sequencer side.
    modport slave (
        input  x, y, in_valid, add_sum, add_cout,
        output in_ready, add_a, add_b, seg_in, digit_en, res_valid
    );
endinterface

// File: rtl/seg_add_scan_ctrl.sv
// Sequencer and display scanner for the 4-bit add-and-display datapath.
// Latches an operand pair, lets the external adder settle, captures x/y/carry/sum
// into display registers, and scans them through one shared seven-segment decoder.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for an operand pair; in_ready high
// SETTLE | operands latched, waiting SETTLE_CYC cycles for the adder
module seg_add_scan_ctrl #(
    parameter int DIV_WIDTH  = 16,
    parameter int DIV_MAX    = 49999,
    parameter int SETTLE_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_add_scan_if.slave bus
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            capture;
    logic            settle_last;
    logic [SW-1:0]   settle_cnt;

    logic [3:0]      opa_q;
    logic [3:0]      opb_q;
    logic [3:0]      disp_sum;
    logic [3:0]      disp_c;
    logic [3:0]      disp_x;
    logic [3:0]      disp_y;
    logic            res_valid_q;

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;
    logic [1:0]           idx;
    logic [1:0]           idx_next;
    logic [3:0]           seg_next;
    logic [3:0]           seg_q;
    logic [3:0]           en_q;

    assign settle_last = (settle_cnt == SW'(SETTLE_CYC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state decode plus the accept/capture strobes for the datapath.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_last) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, settle timer and display capture; display updates all at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            opa_q       <= 4'd0;
            opb_q       <= 4'd0;
            settle_cnt  <= '0;
            disp_sum    <= 4'd0;
            disp_c      <= 4'd0;
            disp_x      <= 4'd0;
            disp_y      <= 4'd0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= capture;
            if (accept) begin
                opa_q      <= bus.x;
                opb_q      <= bus.y;
                settle_cnt <= '0;
            end else if (state == SETTLE && !settle_last) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
            if (capture) begin
                disp_sum <= bus.add_sum;
                disp_c   <= {3'b000, bus.add_cout};
                disp_x   <= opa_q;
                disp_y   <= opb_q;
            end
        end
    end

    assign tick     = (div_cnt == DIV_WIDTH'(DIV_MAX));
    assign idx_next = tick ? idx + 2'd1 : idx;

    // Digit select: 0 sum, 1 carry, 2 y, 3 x.
    always_comb begin
        seg_next = disp_sum;
        case (idx_next)
            2'd0: seg_next = disp_sum;
            2'd1: seg_next = disp_c;
            2'd2: seg_next = disp_y;
            2'd3: seg_next = disp_x;
            default: seg_next = disp_sum;
        endcase
    end

    // Free-running refresh prescaler and registered digit drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= 2'd0;
            seg_q   <= 4'd0;
            en_q    <= 4'b1110;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
            idx     <= idx_next;
            seg_q   <= seg_next;
            en_q    <= ~(4'b0001 << idx_next);
        end
    end

    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.add_a     = opa_q;
    assign bus.add_b     = opb_q;
    assign bus.seg_in    = seg_q;
    assign bus.digit_en  = en_q;
    assign bus.res_valid = res_valid_q;

endmodule
